// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-back arbiter (ALU/LSU) with busy scoreboard
//
// Shares the single register-file write port between the ALU and the LSU,
// registers the winning write for one cycle, and tracks destinations with
// writes in flight so the issue stage can be held on RAW/WAW hazards.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   issue_valid, issue_rd          instruction being dispatched and its destination
//   q_rs1, q_rs2                   sources of the instruction in issue
//   stall                          hazard against an in-flight write; issue must hold
//   alu_valid/alu_rd/alu_wd        ALU write-back request, alu_ready = accepted
//   lsu_valid/lsu_rd/lsu_wd        LSU write-back request, lsu_ready = accepted
//   rf_rd, rf_wd, rf_we            register-file write port
//   busy                           scoreboard, bit n = write to register n pending

module regfile_wb_arbiter #(
   parameter int XLEN      = 32,
   parameter int AW        = 5,
   parameter bit ALU_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid,
   input  logic [AW-1:0]         issue_rd,
   input  logic [AW-1:0]         q_rs1,
   input  logic [AW-1:0]         q_rs2,
   output logic                  stall,
   input  logic                  alu_valid,
   input  logic [AW-1:0]         alu_rd,
   input  logic [XLEN-1:0]       alu_wd,
   output logic                  alu_ready,
   input  logic                  lsu_valid,
   input  logic [AW-1:0]         lsu_rd,
   input  logic [XLEN-1:0]       lsu_wd,
   output logic                  lsu_ready,
   output logic [AW-1:0]         rf_rd,
   output logic [XLEN-1:0]       rf_wd,
   output logic                  rf_we,
   output logic [(1<<AW)-1:0]    busy
);

   localparam int NREG = 1 << AW;

   // 1 when the most recent accepted write-back came from the ALU
   logic            last_alu;
   logic            grant_alu;
   logic            grant_lsu;
   logic            accept;
   logic            issue_fire;
   logic [AW-1:0]   win_rd;
   logic [XLEN-1:0] win_wd;
   logic [NREG-1:0] busy_nxt;

   // On a conflict the requester that did not win last time goes first,
   // which makes back-to-back conflicts strictly alternate.
   always_comb begin
      grant_alu = 1'b0;
      grant_lsu = 1'b0;
      if (alu_valid && lsu_valid) begin
         grant_alu = ~last_alu;
         grant_lsu = last_alu;
      end else begin
         grant_alu = alu_valid;
         grant_lsu = lsu_valid;
      end
   end

   assign alu_ready = grant_alu;
   assign lsu_ready = grant_lsu;
   assign accept    = grant_alu | grant_lsu;
   assign win_rd    = grant_lsu ? lsu_rd : alu_rd;
   assign win_wd    = grant_lsu ? lsu_wd : alu_wd;

   // Stall looks only at the registered scoreboard; a write-back accepted
   // this cycle clears its hazard from the next cycle on.
   assign stall = ((q_rs1    != '0) && busy[q_rs1])
                | ((q_rs2    != '0) && busy[q_rs2])
                | ((issue_rd != '0) && busy[issue_rd]);

   assign issue_fire = issue_valid & ~stall;

   // Clear first, then set: a newly issued producer of the same register
   // must stay tracked even when an older write to it retires now.
   always_comb begin
      busy_nxt = busy;
      if (accept)
         busy_nxt[win_rd] = 1'b0;
      if (issue_fire && (issue_rd != '0))
         busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_rd    <= '0;
         rf_wd    <= '0;
         busy     <= '0;
         last_alu <= ~ALU_FIRST;
      end else begin
         busy  <= busy_nxt;
         rf_we <= accept && (win_rd != '0);
         if (accept) begin
            rf_rd    <= win_rd;
            rf_wd    <= win_wd;
            last_alu <= grant_alu;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic [4:0]  issue_rd, q_rs1, q_rs2;
   logic        stall;
   logic        alu_valid, lsu_valid, alu_ready, lsu_ready;
   logic [4:0]  alu_rd, lsu_rd, rf_rd;
   logic [31:0] alu_wd, lsu_wd, rf_wd;
   logic        rf_we;
   logic [31:0] busy;

   int total = 0;
   int bad   = 0;

   // reference model state
   int          m_last;          // 0: ALU had last grant, 1: LSU had last grant
   bit          m_busy [32];
   bit          m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_wd;
   bit          m_alu_acc = 0;
   bit          m_lsu_acc = 0;

   regfile_wb_arbiter #(.XLEN(32), .AW(5), .ALU_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .q_rs1(q_rs1), .q_rs2(q_rs2), .stall(stall),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd), .lsu_ready(lsu_ready),
      .rf_rd(rf_rd), .rf_wd(rf_wd), .rf_we(rf_we), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit hazard(input logic [4:0] r);
      return (r != 5'd0) && m_busy[r];
   endfunction

   // Model: checks every cycle at the falling edge, then advances to the
   // state the next rising edge must produce.
   always @(negedge clk) begin : cmp
      bit ga, gl, es;
      logic [31:0] eb;
      if (rst) begin
         m_last = 1;
         foreach (m_busy[i]) m_busy[i] = 1'b0;
         m_we = 1'b0;
         m_rd = 5'd0;
         m_wd = 32'd0;
      end
      if (alu_valid && lsu_valid) begin
         ga = (m_last == 1);
         gl = !ga;
      end else begin
         ga = alu_valid;
         gl = lsu_valid;
      end
      es = hazard(q_rs1) || hazard(q_rs2) || hazard(issue_rd);
      for (int i = 0; i < 32; i++) eb[i] = m_busy[i];
      chk("alu_ready", 32'(alu_ready), 32'(ga));
      chk("lsu_ready", 32'(lsu_ready), 32'(gl));
      chk("stall",     32'(stall),     32'(es));
      chk("busy",      busy,           eb);
      chk("rf_we",     32'(rf_we),     32'(m_we));
      chk("rf_rd",     32'(rf_rd),     32'(m_rd));
      chk("rf_wd",     rf_wd,          m_wd);
      m_alu_acc = ga && !rst;
      m_lsu_acc = gl && !rst;
      if (!rst) begin
         if (ga || gl) begin
            m_rd   = ga ? alu_rd : lsu_rd;
            m_wd   = ga ? alu_wd : lsu_wd;
            m_we   = (m_rd != 5'd0);
            m_last = ga ? 0 : 1;
            m_busy[m_rd] = 1'b0;
         end else begin
            m_we = 1'b0;
         end
         if (issue_valid && !es && issue_rd != 5'd0)
            m_busy[issue_rd] = 1'b1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int na, nl, nwe;
      rst = 1'b1;
      issue_valid = 0; issue_rd = 0; q_rs1 = 0; q_rs2 = 0;
      alu_valid = 0; alu_rd = 0; alu_wd = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_wd = 0;
      #1;
      chk("reset rf_we", 32'(rf_we), 0);
      chk("reset busy",  busy, 0);
      chk("reset rf_rd", 32'(rf_rd), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // first conflict after reset goes to the ALU, then the LSU
      tick;
      alu_valid = 1; alu_rd = 5; alu_wd = 32'hDEADBEEF;
      lsu_valid = 1; lsu_rd = 6; lsu_wd = 32'h12345678;
      @(negedge clk);
      chk("t1 alu_ready c0", 32'(alu_ready), 1);
      chk("t1 lsu_ready c0", 32'(lsu_ready), 0);
      tick; alu_valid = 0;
      @(negedge clk);
      chk("t1 lsu_ready c1", 32'(lsu_ready), 1);
      chk("t1 rf_we c1", 32'(rf_we), 1);
      chk("t1 rf_rd c1", 32'(rf_rd), 5);
      chk("t1 rf_wd c1", rf_wd, 32'hDEADBEEF);
      tick; lsu_valid = 0;
      @(negedge clk);
      chk("t1 rf_we c2", 32'(rf_we), 1);
      chk("t1 rf_rd c2", 32'(rf_rd), 6);
      chk("t1 rf_wd c2", rf_wd, 32'h12345678);

      // sustained conflict: strict alternation, one write per cycle
      tick;
      alu_valid = 1; alu_rd = 10; alu_wd = 32'hA0A0A0A0;
      lsu_valid = 1; lsu_rd = 11; lsu_wd = 32'hB1B1B1B1;
      na = 0; nl = 0; nwe = 0;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (k < 8) begin
            na += int'(alu_ready);
            nl += int'(lsu_ready);
            chk("t2 alternate", 32'(alu_ready), 32'((k % 2) == 0));
         end
         if (k >= 1) nwe += int'(rf_we);
         if (k == 7) begin
            tick; alu_valid = 0; lsu_valid = 0;
         end
      end
      chk("t2 alu grants", 32'(na), 4);
      chk("t2 lsu grants", 32'(nl), 4);
      chk("t2 write cycles", 32'(nwe), 8);

      // RAW hazard set by issue, cleared by the ALU write-back
      tick; issue_valid = 1; issue_rd = 7;
      @(negedge clk); chk("t3 stall before", 32'(stall), 0);
      tick; issue_valid = 0; issue_rd = 0; q_rs1 = 7;
      @(negedge clk);
      chk("t3 busy7 set", 32'(busy[7]), 1);
      chk("t3 stall set", 32'(stall), 1);
      tick; alu_valid = 1; alu_rd = 7; alu_wd = 32'h77;
      @(negedge clk);
      chk("t3 alu_ready", 32'(alu_ready), 1);
      chk("t3 stall no bypass", 32'(stall), 1);
      tick; alu_valid = 0;
      @(negedge clk);
      chk("t3 busy7 clear", 32'(busy[7]), 0);
      chk("t3 stall clear", 32'(stall), 0);

      // set and clear of the same register in one cycle: set wins
      tick; q_rs1 = 0; issue_valid = 1; issue_rd = 9;
      lsu_valid = 1; lsu_rd = 9; lsu_wd = 32'h99;
      @(negedge clk);
      chk("t4 lsu_ready", 32'(lsu_ready), 1);
      chk("t4 stall", 32'(stall), 0);
      tick; issue_valid = 0; issue_rd = 0; lsu_valid = 0;
      @(negedge clk);
      chk("t4 busy9 kept", 32'(busy[9]), 1);
      chk("t4 rf_rd", 32'(rf_rd), 9);
      tick; lsu_valid = 1; lsu_rd = 9; lsu_wd = 32'h999;
      @(negedge clk); chk("t4 lsu_ready 2", 32'(lsu_ready), 1);
      tick; lsu_valid = 0;
      @(negedge clk); chk("t4 busy empty", busy, 0);

      // writes to x0 handshake but never write
      tick; alu_valid = 1; alu_rd = 0; alu_wd = 32'hFFFFFFFF;
      @(negedge clk); chk("t5 alu_ready", 32'(alu_ready), 1);
      tick; alu_valid = 0; issue_valid = 1; issue_rd = 0;
      @(negedge clk);
      chk("t5 rf_we", 32'(rf_we), 0);
      chk("t5 rf_wd", rf_wd, 32'hFFFFFFFF);
      chk("t5 stall", 32'(stall), 0);
      tick; issue_valid = 0;
      @(negedge clk); chk("t5 busy0", busy, 0);

      // asynchronous reset between edges
      tick; issue_valid = 1; issue_rd = 7;
      tick; issue_rd = 10; alu_valid = 1; alu_rd = 3; alu_wd = 32'h33;
      tick; issue_valid = 0; issue_rd = 0; alu_valid = 0;
      #1;
      chk("t6 busy pre", busy, 32'h00000480);
      chk("t6 rf_we pre", 32'(rf_we), 1);
      rst = 1'b1;
      #1;
      chk("t6 busy rst", busy, 0);
      chk("t6 rf_we rst", 32'(rf_we), 0);
      chk("t6 rf_rd rst", 32'(rf_rd), 0);
      chk("t6 rf_wd rst", rf_wd, 0);
      tick; rst = 1'b0;
      alu_valid = 1; alu_rd = 4; alu_wd = 32'h44;
      lsu_valid = 1; lsu_rd = 5; lsu_wd = 32'h55;
      @(negedge clk);
      chk("t6 alu first", 32'(alu_ready), 1);
      chk("t6 lsu second", 32'(lsu_ready), 0);
      tick; alu_valid = 0;
      @(negedge clk); chk("t6 lsu next", 32'(lsu_ready), 1);
      tick; lsu_valid = 0;

      // randomized traffic; requesters hold until accepted
      for (int c = 0; c < 3000; c++) begin
         tick;
         if (!alu_valid || m_alu_acc) begin
            alu_valid = ($urandom_range(0, 2) != 0);
            alu_rd    = 5'($urandom_range(0, 7));
            alu_wd    = $urandom;
         end
         if (!lsu_valid || m_lsu_acc) begin
            lsu_valid = ($urandom_range(0, 2) != 0);
            lsu_rd    = 5'($urandom_range(0, 7));
            lsu_wd    = $urandom;
         end
         issue_valid = 1'($urandom_range(0, 1));
         issue_rd    = 5'($urandom_range(0, 7));
         q_rs1       = 5'($urandom_range(0, 7));
         q_rs2       = 5'($urandom_range(0, 7));
      end
      tick;
      alu_valid = 0; lsu_valid = 0; issue_valid = 0;
      @(negedge clk);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
